// File: rtl/sdram_pattern_tester.sv
// Avalon-MM pattern tester for a 16-bit SDRAM controller slave port:
// writes P(a) = a[15:0] ^ seed over a word region, reads it back pipelined and counts mismatches.
module sdram_pattern_tester #(
  parameter int unsigned ADDR_W      = 22,
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned MAX_PENDING = 7
) (
  input  logic              clk_clk,
  input  logic              reset_reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   word_count,
  input  logic [DATA_W-1:0] seed,
  output logic [ADDR_W-1:0] m_address,
  output logic [1:0]        m_byteenable_n,
  output logic              m_chipselect,
  output logic [DATA_W-1:0] m_writedata,
  output logic              m_read_n,
  output logic              m_write_n,
  input  logic [DATA_W-1:0] m_readdata,
  input  logic              m_readdatavalid,
  input  logic              m_waitrequest,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [15:0]       err_count,
  output logic [ADDR_W-1:0] first_err_addr
);

  localparam int unsigned CNT_W  = ADDR_W + 1;
  localparam int unsigned PEND_W = 4;
  localparam int unsigned ERR_W  = 16;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_WRITE = 3'd1;
  localparam logic [2:0] S_READ  = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]        state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [DATA_W-1:0] seed_q, seed_d;
  logic [CNT_W-1:0]  left_q, left_d;
  logic [PEND_W-1:0] pend_q, pend_d;
  logic [ADDR_W-1:0] cmp_addr_q, cmp_addr_d;
  logic [CNT_W-1:0]  cmp_cnt_q, cmp_cnt_d;
  logic [ERR_W-1:0]  err_q, err_d;
  logic [ADDR_W-1:0] first_q, first_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              pass_q, pass_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              rd_n_q, rd_n_d;
  logic              wr_n_q, wr_n_d;
  logic              cs_q, cs_d;

  logic wr_acc, rd_acc, cmp_en;

  function automatic logic [DATA_W-1:0] pat(input logic [15:0] a, input logic [DATA_W-1:0] s);
    return DATA_W'(a) ^ s;
  endfunction

  // Next-state, command issue and compare logic
  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    count_d    = count_q;
    seed_d     = seed_q;
    left_d     = left_q;
    cmp_addr_d = cmp_addr_q;
    cmp_cnt_d  = cmp_cnt_q;
    err_d      = err_q;
    first_d    = first_q;
    busy_d     = busy_q;
    done_d     = done_q;
    pass_d     = pass_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rd_n_d     = rd_n_q;
    wr_n_d     = wr_n_q;
    cs_d       = cs_q;

    wr_acc = !wr_n_q && !m_waitrequest;
    rd_acc = !rd_n_q && !m_waitrequest;
    cmp_en = m_readdatavalid && ((state_q == S_READ) || (state_q == S_DRAIN));
    pend_d = pend_q + PEND_W'(rd_acc) - PEND_W'(cmp_en);

    if (cmp_en) begin
      cmp_addr_d = cmp_addr_q + ADDR_W'(1);
      cmp_cnt_d  = cmp_cnt_q + CNT_W'(1);
      if (m_readdata != pat(cmp_addr_q[15:0], seed_q)) begin
        if (err_q == '0) first_d = cmp_addr_q;
        if (err_q != {ERR_W{1'b1}}) err_d = err_q + ERR_W'(1);
      end
    end

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          base_d     = base_addr;
          count_d    = word_count;
          seed_d     = seed;
          err_d      = '0;
          first_d    = '0;
          pend_d     = '0;
          cmp_addr_d = base_addr;
          cmp_cnt_d  = '0;
          addr_d     = base_addr;
          left_d     = word_count;
          if (word_count == '0) begin
            state_d = S_DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            pass_d  = 1'b1;
          end else begin
            state_d = S_WRITE;
            busy_d  = 1'b1;
            done_d  = 1'b0;
            pass_d  = 1'b0;
            wdata_d = pat(base_addr[15:0], seed);
            wr_n_d  = 1'b0;
            cs_d    = 1'b1;
          end
        end
      end
      S_WRITE: begin
        if (wr_acc) begin
          if (left_q == CNT_W'(1)) begin
            state_d = S_READ;
            addr_d  = base_q;
            left_d  = count_q;
            wr_n_d  = 1'b1;
            rd_n_d  = 1'b0;
            cs_d    = 1'b1;
          end else begin
            addr_d  = addr_q + ADDR_W'(1);
            wdata_d = pat(addr_d[15:0], seed_q);
            left_d  = left_q - CNT_W'(1);
          end
        end
      end
      S_READ: begin
        // A read is only shown to the slave while the outstanding count has room.
        if (rd_acc) begin
          left_d = left_q - CNT_W'(1);
          if (left_q == CNT_W'(1)) begin
            state_d = S_DRAIN;
            rd_n_d  = 1'b1;
            cs_d    = 1'b0;
          end else begin
            addr_d = addr_q + ADDR_W'(1);
            rd_n_d = !(pend_d < PEND_W'(MAX_PENDING));
            cs_d   = pend_d < PEND_W'(MAX_PENDING);
          end
        end else if (rd_n_q && (pend_d < PEND_W'(MAX_PENDING))) begin
          rd_n_d = 1'b0;
          cs_d   = 1'b1;
        end
      end
      S_DRAIN: begin
        if ((pend_q == '0) && (cmp_cnt_q == count_q)) begin
          state_d = S_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = (err_q == '0);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state_q    <= S_IDLE;
      base_q     <= '0;
      count_q    <= '0;
      seed_q     <= '0;
      left_q     <= '0;
      pend_q     <= '0;
      cmp_addr_q <= '0;
      cmp_cnt_q  <= '0;
      err_q      <= '0;
      first_q    <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rd_n_q     <= 1'b1;
      wr_n_q     <= 1'b1;
      cs_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      count_q    <= count_d;
      seed_q     <= seed_d;
      left_q     <= left_d;
      pend_q     <= pend_d;
      cmp_addr_q <= cmp_addr_d;
      cmp_cnt_q  <= cmp_cnt_d;
      err_q      <= err_d;
      first_q    <= first_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      pass_q     <= pass_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rd_n_q     <= rd_n_d;
      wr_n_q     <= wr_n_d;
      cs_q       <= cs_d;
    end
  end

  assign m_address      = addr_q;
  assign m_byteenable_n = 2'b00;
  assign m_chipselect   = cs_q;
  assign m_writedata    = wdata_q;
  assign m_read_n       = rd_n_q;
  assign m_write_n      = wr_n_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign pass           = pass_q;
  assign err_count      = err_q;
  assign first_err_addr = first_q;

endmodule

// File: tb/tb_sdram_pattern_tester.sv
// Directed bench for sdram_pattern_tester with a negedge-driven Avalon slave memory model.
module tb_sdram_pattern_tester;

  localparam int unsigned ADDR_W = 22;
  localparam int unsigned DATA_W = 16;

  logic              clk_clk = 1'b0;
  logic              reset_reset_n = 1'b1;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] base_addr = '0;
  logic [ADDR_W:0]   word_count = '0;
  logic [DATA_W-1:0] seed = '0;
  logic [ADDR_W-1:0] m_address;
  logic [1:0]        m_byteenable_n;
  logic              m_chipselect;
  logic [DATA_W-1:0] m_writedata;
  logic              m_read_n;
  logic              m_write_n;
  logic [DATA_W-1:0] m_readdata = '0;
  logic              m_readdatavalid = 1'b0;
  logic              m_waitrequest = 1'b0;
  logic              busy;
  logic              done;
  logic              pass;
  logic [15:0]       err_count;
  logic [ADDR_W-1:0] first_err_addr;

  sdram_pattern_tester dut (
    .clk_clk(clk_clk), .reset_reset_n(reset_reset_n), .start(start),
    .base_addr(base_addr), .word_count(word_count), .seed(seed),
    .m_address(m_address), .m_byteenable_n(m_byteenable_n), .m_chipselect(m_chipselect),
    .m_writedata(m_writedata), .m_read_n(m_read_n), .m_write_n(m_write_n),
    .m_readdata(m_readdata), .m_readdatavalid(m_readdatavalid), .m_waitrequest(m_waitrequest),
    .busy(busy), .done(done), .pass(pass), .err_count(err_count), .first_err_addr(first_err_addr)
  );

  always #5 clk_clk = ~clk_clk;

  typedef struct {
    logic [15:0] d;
    int          due;
  } ret_t;

  logic [15:0]       mem [64];
  ret_t              rq [$];
  logic [ADDR_W-1:0] wlog_a [$];
  logic [15:0]       wlog_d [$];
  int                wlog_c [$];
  int cyc = 0, lat = 2, stall_idx = -1, stall_len = 0, stall_cnt = 0;
  int wr_idx = 0, rd_cnt = 0, strobe_cyc = 0, max_pend = 0, wait_cyc = 0;
  int proto_err = 0, hold_err = 0;
  bit flip = 1'b0;
  logic              prev_wait = 1'b0, prev_rd_n = 1'b1, prev_wr_n = 1'b1;
  logic [ADDR_W-1:0] prev_a = '0;
  logic [15:0]       prev_d = '0;

  int n_checks = 0;
  int n_fail = 0;

  // Slave: decides waitrequest/readdatavalid for the coming rising edge and records accepted commands.
  always @(negedge clk_clk) begin
    logic [15:0] rd;
    cyc++;
    m_readdatavalid = 1'b0;
    if (rq.size() > 0 && rq[0].due <= cyc) begin
      m_readdata      = rq[0].d;
      m_readdatavalid = 1'b1;
      rq.delete(0);
    end
    if (!m_read_n && !m_write_n) proto_err++;
    if (m_chipselect != (!m_read_n || !m_write_n)) proto_err++;
    if (prev_wait && (!prev_rd_n || !prev_wr_n) &&
        (m_address != prev_a || m_writedata != prev_d || m_read_n != prev_rd_n || m_write_n != prev_wr_n))
      hold_err++;
    m_waitrequest = 1'b0;
    if (!m_write_n && wr_idx == stall_idx && stall_cnt < stall_len) begin
      m_waitrequest = 1'b1;
      stall_cnt++;
      wait_cyc++;
    end
    if (m_chipselect && !m_waitrequest) begin
      if (!m_write_n) begin
        mem[m_address[5:0]] = m_writedata;
        wlog_a.push_back(m_address);
        wlog_d.push_back(m_writedata);
        wlog_c.push_back(cyc);
        wr_idx++;
      end else if (!m_read_n) begin
        rd = mem[m_address[5:0]];
        if (flip && (m_address == 22'h000013 || m_address == 22'h000015)) rd = rd ^ 16'h0001;
        rq.push_back('{d: rd, due: cyc + lat});
        rd_cnt++;
      end
    end
    if (!m_read_n || !m_write_n) strobe_cyc++;
    if (rq.size() > max_pend) max_pend = rq.size();
    prev_wait = m_waitrequest;
    prev_rd_n = m_read_n;
    prev_wr_n = m_write_n;
    prev_a    = m_address;
    prev_d    = m_writedata;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic clear_log();
    wlog_a.delete();
    wlog_d.delete();
    wlog_c.delete();
    wr_idx = 0; rd_cnt = 0; strobe_cyc = 0; max_pend = 0;
    wait_cyc = 0; stall_cnt = 0;
  endtask

  // Called at posedge+1; start is sampled on the next rising edge.
  task automatic run(input logic [ADDR_W-1:0] b, input logic [ADDR_W:0] n, input logic [15:0] s);
    base_addr  = b;
    word_count = n;
    seed       = s;
    start      = 1'b1;
    @(posedge clk_clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int lim);
    for (int i = 0; i < lim && !done; i++) begin
      @(posedge clk_clk);
      #1;
    end
    check("done_timeout", 32'(done), 32'd1);
  endtask

  logic [15:0]       exp1 [8];
  logic [ADDR_W-1:0] wrap_a [4];
  logic [15:0]       wrap_d [4];

  initial begin
    exp1   = '{16'hA5B5, 16'hA5B4, 16'hA5B7, 16'hA5B6, 16'hA5B1, 16'hA5B0, 16'hA5B3, 16'hA5B2};
    wrap_a = '{22'h3FFFFE, 22'h3FFFFF, 22'h000000, 22'h000001};
    wrap_d = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};
    for (int i = 0; i < 64; i++) mem[i] = 16'h0000;

    #2 reset_reset_n = 1'b0;
    repeat (3) @(posedge clk_clk);
    #1;
    check("rst_read_n", 32'(m_read_n), 32'd1);
    check("rst_write_n", 32'(m_write_n), 32'd1);
    check("rst_cs", 32'(m_chipselect), 32'd0);
    check("rst_addr", 32'(m_address), 32'd0);
    check("rst_be_n", 32'(m_byteenable_n), 32'd0);
    check("rst_busy_done_pass", {29'd0, busy, done, pass}, 32'd0);
    check("rst_err", 32'(err_count), 32'd0);
    reset_reset_n = 1'b1;
    @(posedge clk_clk);
    #1;

    // Ideal slave, 2-cycle latency
    lat = 2; clear_log();
    run(22'h000010, 23'd8, 16'hA5A5);
    check("t1_busy", 32'(busy), 32'd1);
    check("t1_first_cmd", 32'(m_write_n), 32'd0);
    check("t1_first_addr", 32'(m_address), 32'h10);
    wait_done(200);
    check("t1_writes", 32'(wr_idx), 32'd8);
    for (int i = 0; i < 8 && i < wlog_d.size(); i++) begin
      check("t1_wdata", 32'(wlog_d[i]), 32'(exp1[i]));
      check("t1_waddr", 32'(wlog_a[i]), 32'h10 + 32'(i));
    end
    if (wlog_c.size() == 8) check("t1_b2b", 32'(wlog_c[7] - wlog_c[0]), 32'd7);
    check("t1_reads", 32'(rd_cnt), 32'd8);
    check("t1_pass", 32'(pass), 32'd1);
    check("t1_err", 32'(err_count), 32'd0);
    check("t1_first_err", 32'(first_err_addr), 32'd0);
    check("t1_busy_end", 32'(busy), 32'd0);

    // Three-cycle stall on the 4th write
    clear_log(); stall_idx = 3; stall_len = 3;
    run(22'h000010, 23'd8, 16'h1234);
    wait_done(200);
    stall_idx = -1;
    check("t2_writes", 32'(wr_idx), 32'd8);
    for (int i = 0; i < 8 && i < wlog_a.size(); i++) begin
      check("t2_waddr", 32'(wlog_a[i]), 32'h10 + 32'(i));
      check("t2_wdata", 32'(wlog_d[i]), 32'(16'h1234 ^ (16'h0010 + 16'(i))));
    end
    check("t2_stalls", 32'(wait_cyc), 32'd3);
    if (wlog_c.size() == 8) check("t2_span", 32'(wlog_c[7] - wlog_c[0]), 32'd10);
    check("t2_hold", 32'(hold_err), 32'd0);
    check("t2_pass", 32'(pass), 32'd1);

    // Corrupted readback at 0x13 and 0x15
    clear_log(); flip = 1'b1;
    run(22'h000010, 23'd8, 16'hA5A5);
    wait_done(200);
    flip = 1'b0;
    check("t3_err", 32'(err_count), 32'd2);
    check("t3_first_err", 32'(first_err_addr), 32'h13);
    check("t3_pass", 32'(pass), 32'd0);

    // Long latency: outstanding reads capped
    clear_log(); lat = 12;
    run(22'h000010, 23'd8, 16'h0F0F);
    wait_done(400);
    check("t4_max_pend", 32'(max_pend), 32'd7);
    check("t4_reads", 32'(rd_cnt), 32'd8);
    check("t4_pass", 32'(pass), 32'd1);
    check("t4_err", 32'(err_count), 32'd0);

    // Address wrap at the top of the space
    clear_log(); lat = 2;
    run(22'h3FFFFE, 23'd4, 16'h0000);
    wait_done(200);
    check("t5_writes", 32'(wr_idx), 32'd4);
    for (int i = 0; i < 4 && i < wlog_a.size(); i++) begin
      check("t5_waddr", 32'(wlog_a[i]), 32'(wrap_a[i]));
      check("t5_wdata", 32'(wlog_d[i]), 32'(wrap_d[i]));
    end
    check("t5_pass", 32'(pass), 32'd1);

    // Zero-length run
    clear_log();
    run(22'h000055, 23'd0, 16'h1111);
    check("t5z_done", 32'(done), 32'd1);
    check("t5z_busy", 32'(busy), 32'd0);
    check("t5z_pass", 32'(pass), 32'd1);
    repeat (5) @(posedge clk_clk);
    #1;
    check("t5z_no_strobe", 32'(strobe_cyc), 32'd0);

    // Reset during READ with three reads outstanding
    clear_log(); lat = 12;
    run(22'h000010, 23'd8, 16'hA5A5);
    for (int i = 0; i < 100 && !(rq.size() == 3 && rd_cnt == 3); i++) begin
      @(posedge clk_clk);
      #1;
    end
    check("t6_pend3", 32'(rq.size()), 32'd3);
    #2 reset_reset_n = 1'b0;
    #1;
    check("t6_rst_read_n", 32'(m_read_n), 32'd1);
    check("t6_rst_write_n", 32'(m_write_n), 32'd1);
    check("t6_rst_cs", 32'(m_chipselect), 32'd0);
    check("t6_rst_addr", 32'(m_address), 32'd0);
    check("t6_rst_flags", {29'd0, busy, done, pass}, 32'd0);
    @(posedge clk_clk);
    @(posedge clk_clk);
    #3 reset_reset_n = 1'b1;
    repeat (20) @(posedge clk_clk);
    #1;
    check("t6_late_drained", 32'(rq.size()), 32'd0);
    check("t6_late_err", 32'(err_count), 32'd0);
    check("t6_late_idle", {30'd0, busy, done}, 32'd0);
    clear_log(); lat = 2;
    run(22'h000010, 23'd8, 16'h5A5A);
    wait_done(200);
    check("t6_rerun_writes", 32'(wr_idx), 32'd8);
    check("t6_rerun_reads", 32'(rd_cnt), 32'd8);
    check("t6_rerun_pass", 32'(pass), 32'd1);
    check("t6_rerun_err", 32'(err_count), 32'd0);

    check("protocol", 32'(proto_err), 32'd0);
    check("hold_stable", 32'(hold_err), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
